// File: rtl/match_log_pkg.sv
// Shared types and defaults for the match event logger: FSM encoding, size defaults, saturating increment.
// Pure declarations; no timing or flow-control behaviour of its own.
package match_log_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_e;

  localparam int CNT_W_DEF      = 8;
  localparam int FIFO_DEPTH_DEF = 8;
  localparam int TOT_W_DEF      = 16;

  // Callers zero-extend into 32 bits and truncate the result back to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max_v);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage

// File: rtl/match_log_fifo.sv
// Synchronous show-ahead FIFO: pop_data is the head entry (0 when empty), 1-cycle write-to-read latency.
// Push while full is dropped unless a pop happens in the same cycle; pop while empty is ignored.
module match_log_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt_q;
  logic             wr_en;
  logic             rd_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign count = cnt_q;

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/match_event_logger.sv
// Measures sample distance between matcher hits into a show-ahead FIFO (1-cycle latency, valid/ready drain,
// drops + sticky overflow when full); MATCH_LOG_TIMEOUT_EN adds a one-shot gap-saturation timeout pulse.
module match_event_logger
  import match_log_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int TOT_W      = TOT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_en,
  input  logic             match_in,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [CNT_W-1:0] rd_data,
  output logic [TOT_W-1:0] total_cnt,
  output logic             overflow
`ifdef MATCH_LOG_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  state_e                    state_q;
  state_e                    state_d;
  logic [CNT_W-1:0]          gap_q;
  logic [CNT_W-1:0]          gap_d;
  logic [TOT_W-1:0]          tot_q;
  logic [TOT_W-1:0]          tot_d;
  logic [TOT_W-1:0]          tot_inc;
  logic [CNT_W-1:0]          interval;
  logic                      hit;
  logic                      push;
  logic                      pop;
  logic                      ovf_q;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

  assign hit      = sample_en && match_in;
  assign interval = CNT_W'(sat_inc(32'(gap_q), 32'(CNT_MAX)));
  assign tot_inc  = TOT_W'(sat_inc(32'(tot_q), 32'(TOT_MAX)));

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    tot_d   = tot_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        // The first hit only arms the measurement; it has no predecessor to measure from.
        if (hit) begin
          state_d = MEASURE;
          gap_d   = '0;
          tot_d   = tot_inc;
        end
      end
      MEASURE: begin
        if (hit) begin
          push  = 1'b1;
          gap_d = '0;
          tot_d = tot_inc;
        end else if (sample_en) begin
          gap_d = interval;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      tot_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      tot_q   <= tot_d;
    end
  end

  assign pop = rd_valid && rd_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (push && fifo_full && !pop) begin
      ovf_q <= 1'b1;
    end
  end

  match_log_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (interval),
    .pop       (pop),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_cnt)
  );

  assign rd_valid  = !fifo_empty;
  assign total_cnt = tot_q;
  assign overflow  = ovf_q;

  occupancy_bound: assert property (@(posedge clk) disable iff (rst)
    fifo_cnt <= ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));

`ifdef MATCH_LOG_TIMEOUT_EN
  logic timeout_q;

  // Fires on the single transition into saturation; a saturated gap stays put so it cannot refire.
  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= (state_q == MEASURE) && sample_en && !match_in &&
                   (gap_q == CNT_MAX - CNT_W'(1));
    end
  end

  assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_match_event_logger.sv
// Two logger instances (CNT_W=8 and CNT_W=4) share one stimulus stream and are compared every cycle
// against a sample-index/queue model, with directed scenarios plus hand-computed literal checks.
module tb_match_event_logger;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sample_en;
  logic        match_in;
  logic        rd_ready;
  logic        rv8, rv4, ovf8, ovf4;
  logic [7:0]  rd8;
  logic [3:0]  rd4;
  logic [15:0] tot8, tot4;
`ifdef MATCH_LOG_TIMEOUT_EN
  logic        to8, to4;
  int          to4_pulses = 0;
`endif

  int n_vec = 0;
  int n_err = 0;
  bit checking = 1'b0;

  int mq [2][$];
  int prev [2];
  int tot [2];
  bit ovf [2];
  bit to_exp [2];
  int maxv [2] = '{255, 15};
  int sidx;

  match_event_logger #(.CNT_W(8), .FIFO_DEPTH(8), .TOT_W(16)) u8 (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .match_in  (match_in),
    .rd_valid  (rv8),
    .rd_ready  (rd_ready),
    .rd_data   (rd8),
    .total_cnt (tot8),
    .overflow  (ovf8)
`ifdef MATCH_LOG_TIMEOUT_EN
    ,
    .timeout   (to8)
`endif
  );

  match_event_logger #(.CNT_W(4), .FIFO_DEPTH(8), .TOT_W(16)) u4 (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .match_in  (match_in),
    .rd_valid  (rv4),
    .rd_ready  (rd_ready),
    .rd_data   (rd4),
    .total_cnt (tot4),
    .overflow  (ovf4)
`ifdef MATCH_LOG_TIMEOUT_EN
    ,
    .timeout   (to4)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_vec++;
    if (act !== 32'(exp)) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int head(input int i);
    return (mq[i].size() > 0) ? mq[i][0] : 0;
  endfunction

  // Model: intervals are differences of sample indices between hits; the FIFO is a plain queue.
  always @(posedge clk) begin
    bit full;
    bit popped;
    int iv;
    if (rst) begin
      sidx = 0;
      for (int i = 0; i < 2; i++) begin
        mq[i].delete();
        prev[i]   = -1;
        tot[i]    = 0;
        ovf[i]    = 1'b0;
        to_exp[i] = 1'b0;
      end
    end else begin
      if (sample_en) sidx++;
      for (int i = 0; i < 2; i++) begin
        full      = (mq[i].size() >= 8);
        popped    = (mq[i].size() > 0) && rd_ready;
        to_exp[i] = 1'b0;
        if (popped) void'(mq[i].pop_front());
        if (sample_en && match_in) begin
          if (prev[i] >= 0) begin
            iv = (sidx - prev[i] > maxv[i]) ? maxv[i] : sidx - prev[i];
            if (!full || popped) mq[i].push_back(iv);
            else ovf[i] = 1'b1;
          end
          prev[i] = sidx;
          if (tot[i] < 65535) tot[i]++;
        end else if (sample_en && prev[i] >= 0 && (sidx - prev[i] == maxv[i])) begin
          to_exp[i] = 1'b1;
        end
      end
    end
    #1;
    if (checking) begin
      chk("rd_valid8", 32'(rv8), int'(mq[0].size() > 0));
      chk("rd_data8", 32'(rd8), head(0));
      chk("total8", 32'(tot8), tot[0]);
      chk("overflow8", 32'(ovf8), int'(ovf[0]));
      chk("rd_valid4", 32'(rv4), int'(mq[1].size() > 0));
      chk("rd_data4", 32'(rd4), head(1));
      chk("total4", 32'(tot4), tot[1]);
      chk("overflow4", 32'(ovf4), int'(ovf[1]));
`ifdef MATCH_LOG_TIMEOUT_EN
      chk("timeout8", 32'(to8), int'(to_exp[0]));
      chk("timeout4", 32'(to4), int'(to_exp[1]));
      if (to4 === 1'b1) to4_pulses++;
`endif
    end
  end

  task automatic cyc(input bit se, input bit mi, input bit rr);
    sample_en = se;
    match_in  = mi;
    rd_ready  = rr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int last;
    int pct;
    rst       = 1'b1;
    sample_en = 1'b0;
    match_in  = 1'b0;
    rd_ready  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checking = 1'b1;
    rst = 1'b0;
    chk("reset_rd_valid", 32'(rv8), 0);
    chk("reset_rd_data", 32'(rd8), 0);
    chk("reset_total", 32'(tot8), 0);
    chk("reset_overflow", 32'(ovf8), 0);

    // Hits on samples 3, 4, 9 -> intervals 1 and 5.
    for (int s = 1; s <= 10; s++) cyc(1, (s == 3) || (s == 4) || (s == 9), 0);
    chk("pat_total", 32'(tot8), 3);
    chk("pat_valid", 32'(rv8), 1);
    chk("pat_head", 32'(rd8), 1);
    cyc(0, 0, 1);
    chk("pat_second", 32'(rd8), 5);

    // Two-cycle reset while matches keep arriving.
    rst = 1'b1;
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    rst = 1'b0;
    chk("midrst_valid", 32'(rv8), 0);
    chk("midrst_total", 32'(tot8), 0);
    chk("midrst_overflow", 32'(ovf8), 0);

    // Sample every other cycle, hits on sample indices 2 and 6, match_in high off-sample.
    do_reset();
    for (int c = 0; c < 14; c++) begin
      if (c % 2 == 0) cyc(1, (c / 2 + 1 == 2) || (c / 2 + 1 == 6), 0);
      else cyc(0, 1, 0);
    end
    chk("sparse_total", 32'(tot8), 2);
    chk("sparse_head", 32'(rd8), 4);
    cyc(0, 0, 1);
    chk("sparse_single", 32'(rv8), 0);

    // Long gap: 20 misses between hits saturates the narrow counter.
    do_reset();
`ifdef MATCH_LOG_TIMEOUT_EN
    to4_pulses = 0;
`endif
    cyc(1, 1, 0);
    repeat (20) cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("sat_narrow", 32'(rd4), 15);
    chk("sat_wide", 32'(rd8), 21);
`ifdef MATCH_LOG_TIMEOUT_EN
    chk("timeout_pulses", 32'(to4_pulses), 1);
`endif

    // Ten intervals 1..10 with reader stalled: first eight kept, overflow sticks.
    do_reset();
    cyc(1, 1, 0);
    for (int k = 0; k < 10; k++) begin
      repeat (k) cyc(1, 0, 0);
      cyc(1, 1, 0);
    end
    chk("ovf_flag", 32'(ovf8), 1);
    chk("ovf_total", 32'(tot8), 11);
    for (int k = 1; k <= 8; k++) begin
      chk("drain_valid", 32'(rv8), 1);
      chk("drain_data", 32'(rd8), k);
      cyc(0, 0, 1);
    end
    chk("drain_empty", 32'(rv8), 0);

    // Full FIFO with simultaneous hit and pop: no drop, new interval lands last.
    do_reset();
    repeat (9) cyc(1, 1, 0);
    repeat (3) cyc(1, 0, 0);
    cyc(1, 1, 1);
    chk("fullpp_overflow", 32'(ovf8), 0);
    n = 0;
    last = -1;
    while (rv8 === 1'b1 && n < 20) begin
      last = int'(rd8);
      n++;
      cyc(0, 0, 1);
    end
    chk("fullpp_occupancy", 32'(n), 8);
    chk("fullpp_last", 32'(last), 4);

    // Random traffic at several hit densities with occasional resets.
    do_reset();
    for (int blk = 0; blk < 6; blk++) begin
      pct = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 12 : 40);
      repeat (500) begin
        rst = ($urandom_range(0, 299) == 0);
        cyc($urandom_range(0, 99) < 75, $urandom_range(0, 99) < pct, 1'($urandom_range(0, 1)));
      end
    end
    rst = 1'b0;
    cyc(0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/match_event_logger.md
Name: match_event_logger

Overview:
- Downstream stage of the serial pattern-matcher FSM.
- Consumes the 1-cycle `match` pulse stream and the per-bit sample strobe.
- Measures the distance, in input samples, between consecutive matches.
- Buffers those distances in a small FIFO drained by a valid/ready reader, and keeps a saturating total-match count.

Parameters:
- CNT_W, 8, width of interval counter and FIFO data; intervals saturate at 2^CNT_W-1.
- FIFO_DEPTH, 8, number of interval entries buffered; power of two, at least 2.
- TOT_W, 16, width of the saturating total-match counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- sample_en  input  1  high for one cycle per consumed input bit (same cycle the matcher evaluates data_in).
- match_in  input  1  matcher output; only meaningful when sample_en=1.
- rd_valid  output  1  FIFO non-empty; rd_data holds the oldest interval.
- rd_ready  input  1  reader accepts rd_data when rd_valid&rd_ready.
- rd_data  output  CNT_W  oldest buffered interval.
- total_cnt  output  TOT_W  matches seen since reset, saturating.
- overflow  output  1  sticky: an interval was dropped because the FIFO was full.
- timeout  output  1  present only with MATCH_LOG_TIMEOUT_EN; see Optional Feature.

Behaviour:
- Reset: every output reads 0 in the cycle after rst is sampled high. This covers rd_valid, rd_data, total_cnt, overflow and timeout. FIFO pointers clear, gap_cnt=0, state=IDLE. Reset mid-operation discards buffered entries.
- Match event: hit = sample_en & match_in. A cycle with sample_en=0 is ignored entirely.
- State machine, two states:
  - IDLE: no match yet. On hit → MEASURE, gap_cnt←0, total_cnt+1, no FIFO push. The first match has no predecessor.
  - MEASURE, sample_en & !match_in: gap_cnt←sat(gap_cnt+1).
  - MEASURE, hit: push interval=sat(gap_cnt+1), then gap_cnt←0 and total_cnt+1.
  - MEASURE has no exit except rst.
- Interval definition: the number of sample_en cycles from the previous hit (exclusive) to this hit (inclusive). Back-to-back hits on consecutive samples give 1.
- Saturation: gap_cnt and the pushed interval clamp at 2^CNT_W-1. total_cnt clamps at 2^TOT_W-1 and never wraps.
- Latency: a hit sampled at rising edge n is visible on rd_data/rd_valid after edge n (1 cycle) when the FIFO was empty. total_cnt updates after the same edge.
- FIFO: show-ahead. rd_data is the head entry whenever rd_valid=1, and is held stable until popped. Pop = rd_valid & rd_ready. rd_ready with rd_valid=0 has no effect.
- Full + push, no pop: entry dropped, overflow←1 (sticky until rst). Counters still update.
- Full + push + pop in the same cycle: both occur, no drop, occupancy unchanged.
- Empty + push + pop in the same cycle: pop ignored (rd_valid was 0); push stored.
- Pointers wrap modulo FIFO_DEPTH. A separate occupancy count of log2(FIFO_DEPTH)+1 bits distinguishes full from empty.

Optional Feature:
- Macro: MATCH_LOG_TIMEOUT_EN.
- Defined: the timeout port exists. It pulses high for exactly 1 cycle, after the edge where gap_cnt reaches 2^CNT_W-1 in MEASURE. It does not pulse again until a hit resets gap_cnt.
- Undefined: the timeout port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package match_log_pkg holds:
  - the state encoding (IDLE=1'b0, MEASURE=1'b1);
  - the default CNT_W, FIFO_DEPTH and TOT_W constants;
  - a saturating-increment function.
- One sub-module: match_log_fifo, a parameterised synchronous show-ahead FIFO (width, depth) with push, pop, full, empty and count.
- The top holds the FSM, the gap/total counters and the overflow flag.

Test Plan:
- Reset: drive rst=1 for 2 cycles during activity → rd_valid=0, total_cnt=0, overflow=0; buffered entries gone.
- Hit pattern on samples 3, 4, 9 (sample_en every cycle), rd_ready=0 → FIFO holds 1, 5; total_cnt=3; rd_valid=1 with rd_data=1.
- sample_en only every other cycle, hits on sample indices 2 and 6 → single entry 4. Cycles with match_in=1 but sample_en=0 are ignored.
- CNT_W=4, 20 non-hit samples between hits → entry=15.
- CNT_W=4 with MATCH_LOG_TIMEOUT_EN → exactly one timeout pulse, at gap_cnt=15.
- rd_ready=0, 10 intervals pushed with FIFO_DEPTH=8 → 8 stored (first 8 intervals), overflow=1, total_cnt=11. Then hold rd_ready=1 → 8 pops in order, rd_valid falls after the last.
- FIFO full, simultaneous hit and pop → occupancy stays 8, overflow stays 0, new interval appears last.
